// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request channel, with programmable wait states and a one-cycle response pulse.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (reject accesses whose req_addr[1:0] != 2'b00).
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          accept;
    logic          enter_resp;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic [31:0]   offset;
    logic          in_range;
    logic          misaligned;
    logic          c_err;
    logic [AW-1:0] c_index;

    logic [31:0]   mem [DEPTH_WORDS];

    assign req_ready = (state != WAIT);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero latency the commit happens on the accept edge, so the live request fields are used.
    always_comb begin
        if (LATENCY == 0) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_we    = lat_we;
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
            c_be    = lat_be;
        end
    end

    assign offset   = c_addr - BASE_ADDR;
    assign in_range = (c_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign c_index  = offset[AW+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign misaligned = (c_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign c_err = !in_range || misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end

    // RAM contents survive reset; the reset term blocks a zero-latency accept from writing while held.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && c_we && !c_err) begin
            for (int n = 0; n < 4; n++) begin
                if (c_be[n]) begin
                    mem[c_index][8*n +: 8] <= c_wdata[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= enter_resp;
            rsp_err   <= enter_resp & c_err;
            if (enter_resp && !c_we && !c_err) begin
                rsp_rdata <= mem[c_index];
            end else begin
                rsp_rdata <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 instance and one LATENCY=0 instance sharing clock and reset.
// Expected responses are queued at accept time and popped by a monitor when rsp_valid is seen.
module tb_dmem_responder;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic reset;

    logic        v2, rdy2, we2, rv2, re2;
    logic [31:0] a2, wd2, rd2;
    logic [3:0]  be2;

    logic        v0, rdy0, we0, rv0, re0;
    logic [31:0] a0, wd0, rd0;
    logic [3:0]  be0;

    int   total;
    int   bad;
    int   cyc;
    bit   mon_en;
    exp_t q2[$];
    exp_t q0[$];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(v2), .req_ready(rdy2), .req_we(we2), .req_addr(a2),
        .req_wdata(wd2), .req_be(be2),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_addr(a0),
        .req_wdata(wd0), .req_be(be0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int which, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input bit expect_rsp, input bit check_ready);
        bit   ok;
        logic rdy;
        exp_t e;
        ok = 1'b0;
        if (which == 0) begin
            v0 = 1'b1; we0 = we; a0 = addr; wd0 = wdata; be0 = be;
        end else begin
            v2 = 1'b1; we2 = we; a2 = addr; wd2 = wdata; be2 = be;
        end
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            rdy = (which == 0) ? rdy0 : rdy2;
            if (check_ready && w == 0) checkOutput("b2b_ready", {31'd0, rdy}, 32'd1);
            if (rdy) ok = 1'b1;
        end
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cyc + 1 + ((which == 0) ? 0 : 2);
            if (expect_rsp) begin
                if (which == 0) q0.push_back(e);
                else q2.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleReq();
        v0 = 1'b0;
        v2 = 1'b0;
    endtask

    // Monitor: pops an expectation on every response pulse and checks outputs stay zero between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!reset) begin
                checkOutput("valid_in_reset", {30'd0, rv2, rv0}, 32'd0);
            end else begin
                if (rv2) begin
                    if (q2.size() == 0) begin
                        checkOutput("l2_unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = q2.pop_front();
                        checkOutput("l2_rdata", rd2, e.rdata);
                        checkOutput("l2_err", {31'd0, re2}, {31'd0, e.err});
                        checkOutput("l2_cycle", cyc, e.due);
                    end
                end else begin
                    checkOutput("l2_idle_zero", {rd2[31:1], rd2[0] | re2}, 32'd0);
                end
                if (rv0) begin
                    if (q0.size() == 0) begin
                        checkOutput("l0_unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = q0.pop_front();
                        checkOutput("l0_rdata", rd0, e.rdata);
                        checkOutput("l0_err", {31'd0, re0}, {31'd0, e.err});
                        checkOutput("l0_cycle", cyc, e.due);
                    end
                end else begin
                    checkOutput("l0_idle_zero", {rd0[31:1], rd0[0] | re0}, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] mis_rd;
        logic        mis_err;
        total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
        v2 = 0; we2 = 0; a2 = 0; wd2 = 0; be2 = 0;
        v0 = 0; we0 = 0; a0 = 0; wd0 = 0; be0 = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #12;
        checkOutput("rst_ready", {30'd0, rdy2, rdy0}, 32'd3);
        checkOutput("rst_valid", {30'd0, rv2, rv0}, 32'd0);
        checkOutput("rst_rdata", rd2 | rd0, 32'd0);
        checkOutput("rst_err", {30'd0, re2, re0}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Full-word store/load, then byte-lane merges and a no-op store.
        applyStimulus(2, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0);
        applyStimulus(2, 1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 1, 0);
        applyStimulus(2, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 1, 0);
        applyStimulus(2, 1, 32'h10, 32'h55007700, 4'hA, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'h10, 32'h0, 4'h0, 32'h55AD77AA, 0, 1, 0);
        idleReq();

        // Range errors at the first out-of-range word, and the last valid word.
        applyStimulus(2, 1, 32'h0, 32'h11111111, 4'hF, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 1, 0);
        applyStimulus(2, 1, 32'h1000, 32'h99999999, 4'hF, 32'h0, 1, 1, 0);
        applyStimulus(2, 0, 32'h0, 32'h0, 4'h0, 32'h11111111, 0, 1, 0);
        applyStimulus(2, 1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 1, 0);
        applyStimulus(2, 0, 32'hFFC, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 1, 0);
        applyStimulus(2, 0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1, 1, 0);
        idleReq();
        repeat (4) @(posedge clk);
        #1;

        // A store dropped by reset during its wait phase must leave the old word in place.
        applyStimulus(2, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, 1, 0);
        applyStimulus(2, 1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, 0);
        idleReq();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(2, 0, 32'h20, 32'h0, 4'h0, 32'h12345678, 0, 1, 0);

`ifdef DMEM_MISALIGN_ERR_EN
        mis_rd = 32'h0; mis_err = 1'b1;
`else
        mis_rd = 32'h55AD77AA; mis_err = 1'b0;
`endif
        applyStimulus(2, 0, 32'h12, 32'h0, 4'h0, mis_rd, mis_err, 1, 0);
        idleReq();
        repeat (5) @(posedge clk);
        #1;

        // Zero-latency instance: back-to-back stores, back-to-back loads, then store-then-load of one word.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'(i * 4), 32'h0100_0000 + 32'(i), 4'hF, 32'h0, 0, 1, i != 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'(i * 4), 32'h0, 4'h0, 32'h0100_0000 + 32'(i), 0, 1, 1);
        end
        applyStimulus(0, 1, 32'h40, 32'h00000077, 4'hF, 32'h0, 0, 1, 1);
        applyStimulus(0, 0, 32'h40, 32'h0, 4'h0, 32'h00000077, 0, 1, 1);
        applyStimulus(0, 0, 32'h2000, 32'h0, 4'h0, 32'h0, 1, 1, 1);
        idleReq();

        repeat (10) @(posedge clk);
        #1;
        checkOutput("l2_queue_drained", q2.size(), 32'd0);
        checkOutput("l0_queue_drained", q0.size(), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
